// File: rtl/acalc_pkg.sv
// Shared constants and FSM state type for the extended address calculator.
package acalc_pkg;

    localparam int unsigned ACALC_DATA_W = 8;
    localparam int unsigned PAGE_BITS    = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HI_LOADED = 2'd1,
        VALID     = 2'd2
    } acalc_state_t;

endpackage

// File: rtl/acalc_offset_alu.sv
// Combinational offset extend + add/subtract datapath with page-cross detection.
module acalc_offset_alu
    import acalc_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = ACALC_DATA_W
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [DATA_W-1:0] lo,
    input  logic [DATA_W-1:0] hi,
    input  logic              m_sign,
    input  logic              m_sub,
    input  logic              wide,
    output logic [ADDR_W-1:0] result,
    output logic              page_x
);

    logic [2*DATA_W-1:0] wide_off;
    logic [ADDR_W-1:0]   offset;

    always_comb begin
        wide_off = {hi, lo};
        // Size casts of signed operands sign-extend; unsigned ones zero-extend.
        if (wide) begin
            offset = m_sign ? ADDR_W'($signed(wide_off)) : ADDR_W'(wide_off);
        end else begin
            offset = m_sign ? ADDR_W'($signed(lo)) : ADDR_W'(lo);
        end
        result = m_sub ? (base - offset) : (base + offset);
        page_x = (result[ADDR_W-1:PAGE_BITS] != base[ADDR_W-1:PAGE_BITS]);
    end

endmodule

// File: rtl/address_calc_ext.sv
// Base +/- offset address calculator with tri-state result bus.
// Define ACALC_WIDE_OFFSET_EN to enable the two-byte offset (high byte preload).
module address_calc_ext
    import acalc_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = ACALC_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire [ADDR_W-1:0]  abus,
    input  logic [DATA_W-1:0] mbus,
    input  logic              loadn,
    input  logic              outn,
    input  logic              m_sign,
    input  logic              m_sub,
    input  logic              m_hi,
    output logic              valid,
    output logic              page_x
);

    acalc_state_t      state, next_state;
    logic [ADDR_W-1:0] result_q;
    logic [DATA_W-1:0] hi_q;
    logic              page_x_q;
    logic [ADDR_W-1:0] alu_result;
    logic              alu_page_x;
    logic              hi_req;
    logic              drive_en;

`ifdef ACALC_WIDE_OFFSET_EN
    assign hi_req = m_hi;
`else
    assign hi_req = m_hi & 1'b0;
`endif

    acalc_offset_alu #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_alu (
        .base   (abus),
        .lo     (mbus),
        .hi     (hi_q),
        .m_sign (m_sign),
        .m_sub  (m_sub),
        .wide   (state == HI_LOADED),
        .result (alu_result),
        .page_x (alu_page_x)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            result_q <= '0;
            hi_q     <= '0;
            page_x_q <= 1'b0;
        end else begin
            state <= next_state;
            if (!loadn) begin
                if (hi_req) begin
                    hi_q <= mbus;
                end else begin
                    result_q <= alu_result;
                    page_x_q <= alu_page_x;
                    hi_q     <= '0;
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        if (!loadn) begin
            next_state = hi_req ? HI_LOADED : VALID;
        end
    end

    always_comb begin
        valid    = (state == VALID);
        page_x   = page_x_q;
        // A pending load owns the bus for its base input, so it beats output enable.
        drive_en = !outn && loadn && valid;
    end

    assign abus = drive_en ? result_q : 'z;

endmodule

// File: tb/tb_address_calc_ext.sv
// Directed self-checking bench for address_calc_ext (default 16/8 widths).
module tb_address_calc_ext;

    logic        clk;
    logic        reset;
    logic [7:0]  mbus;
    logic        loadn, outn, m_sign, m_sub, m_hi;
    logic        valid, page_x;
    logic        tb_en;
    logic [15:0] tb_base;
    wire  [15:0] abus;

    int errors = 0;
    int checks = 0;

    assign abus = tb_en ? tb_base : 'z;

    address_calc_ext #(
        .ADDR_W (16),
        .DATA_W (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .abus   (abus),
        .mbus   (mbus),
        .loadn  (loadn),
        .outn   (outn),
        .m_sign (m_sign),
        .m_sub  (m_sub),
        .m_hi   (m_hi),
        .valid  (valid),
        .page_x (page_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] base, input logic [7:0] m,
                           input logic sign, input logic sub, input logic hi);
        @(negedge clk);
        tb_en   = 1'b1;
        tb_base = base;
        mbus    = m;
        m_sign  = sign;
        m_sub   = sub;
        m_hi    = hi;
        loadn   = 1'b0;
        @(posedge clk);
        #1;
        loadn = 1'b1;
        tb_en = 1'b0;
        m_hi  = 1'b0;
    endtask

    task automatic read_result(input string tag, input logic [15:0] exp_abus,
                               input logic exp_px);
        outn = 1'b0;
        #1;
        chk({tag, "_abus"},  abus, exp_abus);
        chk({tag, "_valid"}, {15'd0, valid}, 16'd1);
        chk({tag, "_pagex"}, {15'd0, page_x}, {15'd0, exp_px});
        outn = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b1; loadn = 1'b1; outn = 1'b1; m_sign = 1'b0; m_sub = 1'b0;
        m_hi = 1'b0; mbus = '0; tb_en = 1'b0; tb_base = '0;
        #12;
        chk("rst_valid", {15'd0, valid}, 16'd0);
        chk("rst_pagex", {15'd0, page_x}, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // 0xFCE1 - 88 = 0xFC89 stays in page 0xFC, so no page crossing.
        do_load(16'd64737, 8'd168, 1'b1, 1'b0, 1'b0);
        read_result("signed_add", 16'd64649, 1'b0);

        do_load(16'd64737, 8'd168, 1'b0, 1'b0, 1'b0);
        read_result("unsigned_add", 16'd64905, 1'b1);

        // Holding loadn high must keep the result across repeated reads.
        repeat (3) @(negedge clk);
        read_result("hold_reread", 16'd64905, 1'b1);

        do_load(16'h0010, 8'h20, 1'b0, 1'b1, 1'b0);
        read_result("unsigned_sub_wrap", 16'hFFF0, 1'b1);

        do_load(16'h0100, 8'hFF, 1'b1, 1'b1, 1'b0);
        read_result("signed_sub_neg", 16'h0101, 1'b0);

        do_load(16'h0100, 8'h01, 1'b0, 1'b1, 1'b0);
        read_result("sub_borrow_page", 16'h00FF, 1'b1);

        do_load(16'hFFFF, 8'h01, 1'b0, 1'b0, 1'b0);
        read_result("add_wrap", 16'h0000, 1'b1);

        // Load and output enable in the same cycle: only the bench drives abus.
        @(negedge clk);
        tb_en = 1'b1; tb_base = 16'h4000; mbus = 8'h05;
        m_sign = 1'b0; m_sub = 1'b0; m_hi = 1'b0;
        loadn = 1'b0; outn = 1'b0;
        #1;
        chk("load_out_contention", abus, 16'h4000);
        @(posedge clk);
        #1;
        loadn = 1'b1; tb_en = 1'b0;
        read_result("load_out_after", 16'h4005, 1'b0);

        // Asynchronous reset mid-cycle: valid drops and the DUT releases abus.
        @(negedge clk);
        #2;
        reset = 1'b1;
        tb_en = 1'b1; tb_base = 16'h5555; outn = 1'b0;
        #1;
        chk("async_rst_valid", {15'd0, valid}, 16'd0);
        chk("async_rst_pagex", {15'd0, page_x}, 16'd0);
        chk("async_rst_bus", abus, 16'h5555);
        outn = 1'b1; tb_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;

`ifdef ACALC_WIDE_OFFSET_EN
        do_load(16'h0000, 8'h12, 1'b0, 1'b0, 1'b1);
        chk("wide_hi_valid", {15'd0, valid}, 16'd0);
        do_load(16'h1000, 8'h34, 1'b0, 1'b0, 1'b0);
        read_result("wide_add", 16'h2234, 1'b1);

        do_load(16'h0000, 8'h12, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        do_load(16'h1000, 8'h34, 1'b0, 1'b0, 1'b0);
        read_result("wide_rst_discard", 16'h1034, 1'b0);
`else
        // Without the wide option, m_hi is ignored and the load completes normally.
        do_load(16'h1000, 8'h34, 1'b0, 1'b0, 1'b1);
        read_result("mhi_ignored", 16'h1034, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
